// File: rtl/fm_modulate.sv
// fm_modulate: baseband FM modulator.
// Pops signed audio samples from an upstream first-word-fall-through FIFO,
// integrates them into a wrapping phase accumulator, and maps the phase
// through a quarter-wave sine table to a cos/sin pair. That pair is written
// as I/Q into two downstream FIFOs in lock-step.
//
// Ports:
//   clk         - sole clock
//   reset       - asynchronous, active-high reset
//   audio_in    - audio sample, Q.BITS signed, valid when audio_empty = 0
//   audio_empty - upstream FIFO empty
//   audio_rd_en - upstream pop strobe (decode of state + flags)
//   real_out    - I sample, cos(phase) in Q.BITS, registered
//   real_wr_en  - I FIFO write strobe
//   real_full   - I FIFO full
//   imag_out    - Q sample, sin(phase) in Q.BITS, registered
//   imag_wr_en  - Q FIFO write strobe, always equal to real_wr_en
//   imag_full   - Q FIFO full
module fm_modulate #(
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned BITS      = 10,
    parameter int unsigned PHASE_W   = 16,
    parameter int unsigned FREQ_GAIN = 8192
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_SIZE-1:0] audio_in,
    input  logic                 audio_empty,
    output logic                 audio_rd_en,
    output logic [DATA_SIZE-1:0] real_out,
    output logic                 real_wr_en,
    input  logic                 real_full,
    output logic [DATA_SIZE-1:0] imag_out,
    output logic                 imag_wr_en,
    input  logic                 imag_full
);

    localparam int unsigned PROD_W = 2 * DATA_SIZE;
    localparam int unsigned IDX_W  = 8;
    // Table magnitudes reach 2^10, so one extra bit plus a sign bit.
    localparam int unsigned MAG_W  = 11;
    localparam int unsigned SIN_W  = MAG_W + 1;

    typedef enum logic [1:0] {
        S_READ   = 2'd0,
        S_PHASE  = 2'd1,
        S_LOOKUP = 2'd2,
        S_WRITE  = 2'd3
    } state_t;

    state_t                       r_state;
    logic signed [DATA_SIZE-1:0]  r_sample;
    logic [PHASE_W-1:0]           r_phase;
    logic signed [DATA_SIZE-1:0]  r_cos;
    logic signed [DATA_SIZE-1:0]  r_sin;

    logic signed [PROD_W-1:0]     w_prod;
    logic [PHASE_W-1:0]           w_inc;
    logic [IDX_W-1:0]             w_idx;
    logic [IDX_W-1:0]             w_cos_idx;
    logic signed [SIN_W-1:0]      w_sin;
    logic signed [SIN_W-1:0]      w_cos;
    logic                         w_write;

    // Quarter-wave table: round(sin(pi/2 * k/64) * 1024), k = 0..64.
    function automatic logic [MAG_W-1:0] sin_lut(input logic [6:0] k);
        logic [MAG_W-1:0] v;
        case (k)
            7'd0:  v = 11'd0;    7'd1:  v = 11'd25;   7'd2:  v = 11'd50;
            7'd3:  v = 11'd75;   7'd4:  v = 11'd100;  7'd5:  v = 11'd125;
            7'd6:  v = 11'd150;  7'd7:  v = 11'd175;  7'd8:  v = 11'd200;
            7'd9:  v = 11'd224;  7'd10: v = 11'd249;  7'd11: v = 11'd273;
            7'd12: v = 11'd297;  7'd13: v = 11'd321;  7'd14: v = 11'd345;
            7'd15: v = 11'd369;  7'd16: v = 11'd392;  7'd17: v = 11'd415;
            7'd18: v = 11'd438;  7'd19: v = 11'd460;  7'd20: v = 11'd483;
            7'd21: v = 11'd505;  7'd22: v = 11'd526;  7'd23: v = 11'd548;
            7'd24: v = 11'd569;  7'd25: v = 11'd590;  7'd26: v = 11'd610;
            7'd27: v = 11'd630;  7'd28: v = 11'd650;  7'd29: v = 11'd669;
            7'd30: v = 11'd688;  7'd31: v = 11'd706;  7'd32: v = 11'd724;
            7'd33: v = 11'd742;  7'd34: v = 11'd759;  7'd35: v = 11'd775;
            7'd36: v = 11'd792;  7'd37: v = 11'd807;  7'd38: v = 11'd822;
            7'd39: v = 11'd837;  7'd40: v = 11'd851;  7'd41: v = 11'd865;
            7'd42: v = 11'd878;  7'd43: v = 11'd891;  7'd44: v = 11'd903;
            7'd45: v = 11'd915;  7'd46: v = 11'd926;  7'd47: v = 11'd936;
            7'd48: v = 11'd946;  7'd49: v = 11'd955;  7'd50: v = 11'd964;
            7'd51: v = 11'd972;  7'd52: v = 11'd980;  7'd53: v = 11'd987;
            7'd54: v = 11'd993;  7'd55: v = 11'd999;  7'd56: v = 11'd1004;
            7'd57: v = 11'd1009; 7'd58: v = 11'd1013; 7'd59: v = 11'd1016;
            7'd60: v = 11'd1019; 7'd61: v = 11'd1021; 7'd62: v = 11'd1023;
            7'd63: v = 11'd1024; 7'd64: v = 11'd1024;
            default: v = 11'd0;
        endcase
        return v;
    endfunction

    // Full-circle sine from the quarter table: bit 6 mirrors, bit 7 negates.
    function automatic logic signed [SIN_W-1:0] full_sin(input logic [IDX_W-1:0] idx);
        logic [6:0]       k;
        logic [MAG_W-1:0] mag;
        k   = idx[6] ? (7'd64 - {1'b0, idx[5:0]}) : {1'b0, idx[5:0]};
        mag = sin_lut(k);
        return idx[7] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    endfunction

    // Phase increment: signed full-width product, arithmetic shift, low bits wrap.
    assign w_prod = $signed({{DATA_SIZE{r_sample[DATA_SIZE-1]}}, r_sample})
                  * $signed(PROD_W'(FREQ_GAIN));
    assign w_inc  = PHASE_W'(w_prod >>> BITS);

    // Cosine is the sine a quarter turn ahead; 8-bit index wraps naturally.
    assign w_idx     = r_phase[PHASE_W-1 -: IDX_W];
    assign w_cos_idx = w_idx + 8'd64;
    assign w_sin     = full_sin(w_idx);
    assign w_cos     = full_sin(w_cos_idx);

    // Strobes are forced low while reset is held so nothing leaks out mid-reset.
    assign audio_rd_en = !reset && (r_state == S_READ) && !audio_empty;
    assign w_write     = !reset && (r_state == S_WRITE) && !real_full && !imag_full;
    assign real_wr_en  = w_write;
    assign imag_wr_en  = w_write;

    assign real_out = r_cos;
    assign imag_out = r_sin;

    // Sequencer and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_READ;
            r_sample <= '0;
            r_phase  <= '0;
            r_cos    <= '0;
            r_sin    <= '0;
        end else begin
            case (r_state)
                S_READ: begin
                    if (!audio_empty) begin
                        r_sample <= $signed(audio_in);
                        r_state  <= S_PHASE;
                    end
                end
                S_PHASE: begin
                    r_phase <= r_phase + w_inc;
                    r_state <= S_LOOKUP;
                end
                S_LOOKUP: begin
                    r_sin   <= DATA_SIZE'(w_sin);
                    r_cos   <= DATA_SIZE'(w_cos);
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    if (!real_full && !imag_full) begin
                        r_state <= S_READ;
                    end
                end
                default: r_state <= S_READ;
            endcase
        end
    end

endmodule
